piece_spawner: RTL and testbench

PIECE_SPAWNER -- requirements
Module: piece_spawner

---
 rtl/piece_spawner_if.sv | 29 ++
 rtl/piece_spawner.sv | 136 +++++++++++++
 tb/tb_piece_spawner.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/piece_spawner_if.sv
// Spawn request, next-piece handshake, board occupancy read port and spawn results.
// The spawner uses the slave modport; the game controller side uses master.
interface piece_spawner_if;
  logic        spawn_req;
  logic [2:0]  next_type;
  logic        Update;
  logic        occ_rd;
  logic [3:0]  occ_x;
  logic [4:0]  occ_y;
  logic        occ_data;
  logic [2:0]  cur_type;
  logic [15:0] blk_x;
  logic [19:0] blk_y;
  logic        busy;
  logic        spawn_done;
  logic        game_over;

  modport slave (
    input  spawn_req, next_type, occ_data,
    output Update, occ_rd, occ_x, occ_y, cur_type, blk_x, blk_y,
           busy, spawn_done, game_over
  );

  modport master (
    output spawn_req, next_type, occ_data,
    input  Update, occ_rd, occ_x, occ_y, cur_type, blk_x, blk_y,
           busy, spawn_done, game_over
  );
endinterface

// File: rtl/piece_spawner.sv
// Places a new piece in the spawn frame, probes the four target cells on the board,
// and raises a sticky game_over if any of them is filled or off the board.
module piece_spawner #(
  parameter int GAME_LENGTH = 10,
  parameter int GAME_HEIGHT = 20,
  parameter int SPAWN_X     = 3,
  parameter int SPAWN_Y     = 0
) (
  input  logic           CLK_25M,
  input  logic           key_reset_n,
  piece_spawner_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD0, WT0, RD1, WT1, RD2, WT2, RD3, WT3, OVER
  } state_e;

  state_e      state_q;
  logic [2:0]  type_d, type_q;
  logic [15:0] blkX_d, blkX_q;
  logic [19:0] blkY_d, blkY_q;
  logic [3:0]  oob_d, oob_q;
  logic        update_q, busy_q, done_q, over_q, coll_q;
  logic [7:0]  shapeI, shapeJ;
  logic [1:0]  rdIdx, wtIdx;
  logic        rdActive;
  logic        wtHit;

  // Shape table: 2-bit column/row offsets, block n in bits [2n+1:2n]; type 0 behaves as the square.
  always_comb begin
    type_d = (bus.next_type == 3'd0) ? 3'd4 : bus.next_type;
    shapeI = '0;
    shapeJ = '0;
    blkX_d = '0;
    blkY_d = '0;
    oob_d  = '0;
    case (type_d)
      3'd1:    begin shapeI = {2'd3, 2'd2, 2'd1, 2'd0}; shapeJ = {2'd2, 2'd2, 2'd2, 2'd2}; end
      3'd2:    begin shapeI = {2'd2, 2'd1, 2'd0, 2'd0}; shapeJ = {2'd2, 2'd2, 2'd2, 2'd1}; end
      3'd3:    begin shapeI = {2'd2, 2'd2, 2'd1, 2'd0}; shapeJ = {2'd2, 2'd1, 2'd2, 2'd2}; end
      3'd5:    begin shapeI = {2'd2, 2'd1, 2'd1, 2'd0}; shapeJ = {2'd1, 2'd2, 2'd1, 2'd2}; end
      3'd6:    begin shapeI = {2'd2, 2'd1, 2'd1, 2'd0}; shapeJ = {2'd2, 2'd2, 2'd1, 2'd2}; end
      3'd7:    begin shapeI = {2'd2, 2'd1, 2'd1, 2'd0}; shapeJ = {2'd2, 2'd2, 2'd1, 2'd1}; end
      default: begin shapeI = {2'd2, 2'd2, 2'd1, 2'd1}; shapeJ = {2'd2, 2'd1, 2'd2, 2'd1}; end
    endcase
    for (int n = 0; n < 4; n++) begin
      blkX_d[4*n +: 4] = 4'(SPAWN_X) + {2'b00, shapeI[2*n +: 2]};
      blkY_d[5*n +: 5] = 5'(SPAWN_Y) + {3'b000, shapeJ[2*n +: 2]};
      oob_d[n] = ({28'd0, blkX_d[4*n +: 4]} >= 32'(GAME_LENGTH)) ||
                 ({27'd0, blkY_d[5*n +: 5]} >= 32'(GAME_HEIGHT));
    end
  end

  always_comb begin
    rdActive = 1'b0;
    rdIdx    = 2'd0;
    wtIdx    = 2'd0;
    case (state_q)
      RD0:     rdActive = 1'b1;
      RD1:     begin rdActive = 1'b1; rdIdx = 2'd1; end
      RD2:     begin rdActive = 1'b1; rdIdx = 2'd2; end
      RD3:     begin rdActive = 1'b1; rdIdx = 2'd3; end
      WT1:     wtIdx = 2'd1;
      WT2:     wtIdx = 2'd2;
      WT3:     wtIdx = 2'd3;
      default: ;
    endcase
  end

  // Off-board cells are never read; they simply count as filled when their wait slot ends.
  assign wtHit      = oob_q[wtIdx] | bus.occ_data;
  assign bus.occ_rd = rdActive & ~oob_q[rdIdx];
  assign bus.occ_x  = rdActive ? blkX_q[4*rdIdx +: 4] : 4'd0;
  assign bus.occ_y  = rdActive ? blkY_q[5*rdIdx +: 5] : 5'd0;

  always_ff @(posedge CLK_25M or negedge key_reset_n) begin
    if (!key_reset_n) begin
      state_q  <= IDLE;
      type_q   <= '0;
      blkX_q   <= '0;
      blkY_q   <= '0;
      oob_q    <= '0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      over_q   <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      update_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.spawn_req) begin
            type_q   <= type_d;
            blkX_q   <= blkX_d;
            blkY_q   <= blkY_d;
            oob_q    <= oob_d;
            update_q <= 1'b1;
            busy_q   <= 1'b1;
            coll_q   <= 1'b0;
            state_q  <= RD0;
          end
        end
        RD0: state_q <= WT0;
        WT0: begin coll_q <= coll_q | wtHit; state_q <= RD1; end
        RD1: state_q <= WT1;
        WT1: begin coll_q <= coll_q | wtHit; state_q <= RD2; end
        RD2: state_q <= WT2;
        WT2: begin coll_q <= coll_q | wtHit; state_q <= RD3; end
        RD3: state_q <= WT3;
        WT3: begin
          coll_q <= coll_q | wtHit;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          if (coll_q | wtHit) begin
            over_q  <= 1'b1;
            state_q <= OVER;
          end else begin
            state_q <= IDLE;
          end
        end
        OVER:    state_q <= OVER;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Update     = update_q;
  assign bus.cur_type   = type_q;
  assign bus.blk_x      = blkX_q;
  assign bus.blk_y      = blkY_q;
  assign bus.busy       = busy_q;
  assign bus.spawn_done = done_q;
  assign bus.game_over  = over_q;

endmodule

// File: tb/tb_piece_spawner.sv
// Directed bench for piece_spawner: a default-placed instance against a modelled board,
// plus a right-shifted instance whose piece hangs off the board edge.
module tb_piece_spawner;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   board [0:15][0:31];
  logic [8:0] reads0[$];
  logic [8:0] reads1[$];
  int   updCnt, doneIdx, doneCnt, busyLow, goIdx;
  int   d1Idx;

  piece_spawner_if bus0 ();
  piece_spawner_if bus1 ();

  piece_spawner dut0 (
    .CLK_25M    (clk),
    .key_reset_n(rstN),
    .bus        (bus0)
  );

  piece_spawner #(
    .GAME_LENGTH(10),
    .GAME_HEIGHT(20),
    .SPAWN_X    (8),
    .SPAWN_Y    (0)
  ) dut1 (
    .CLK_25M    (clk),
    .key_reset_n(rstN),
    .bus        (bus1)
  );

  always #20 clk = ~clk;

  // Board memory answers one cycle after each read strobe and logs the cells asked for.
  always @(posedge clk) begin
    bus0.occ_data <= (bus0.occ_rd === 1'b1) ? board[bus0.occ_x][bus0.occ_y] : 1'b0;
    bus1.occ_data <= (bus1.occ_rd === 1'b1) ? board[bus1.occ_x][bus1.occ_y] : 1'b0;
    if (bus0.occ_rd === 1'b1) reads0.push_back({bus0.occ_x, bus0.occ_y});
    if (bus1.occ_rd === 1'b1) reads1.push_back({bus1.occ_x, bus1.occ_y});
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] typ, input bit hold);
    reads0.delete();
    @(negedge clk);
    bus0.next_type = typ;
    bus0.spawn_req = 1'b1;
    @(negedge clk);
    if (!hold) bus0.spawn_req = 1'b0;
  endtask

  task automatic watch0(input int n, output int upd, output int dIdx, output int dCnt,
                        output int bLow, output int gIdx);
    upd = 0; dIdx = -1; dCnt = 0; bLow = 0; gIdx = -1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (bus0.Update === 1'b1) upd++;
      if (bus0.spawn_done === 1'b1) begin
        dCnt++;
        if (dIdx < 0) dIdx = c;
      end
      if (bus0.busy !== 1'b1) bLow++;
      if (bus0.game_over === 1'b1 && gIdx < 0) gIdx = c;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ctrl"}, {bus0.Update, bus0.occ_rd, bus0.occ_x, bus0.occ_y, bus0.cur_type,
                                 bus0.busy, bus0.spawn_done, bus0.game_over}, 32'd0);
    checkOutput({tag, "_blkx"}, bus0.blk_x, 32'd0);
    checkOutput({tag, "_blky"}, bus0.blk_y, 32'd0);
  endtask

  initial begin
    bus0.spawn_req = 1'b0; bus0.next_type = 3'd0;
    bus1.spawn_req = 1'b0; bus1.next_type = 3'd0;
    #5 rstN = 1'b0;
    #10;
    checkReset("rst");
    @(negedge clk);
    rstN = 1'b1;

    // Type 1 on an empty board: flat bar across row 2.
    applyStimulus(3'd1, 1'b0);
    checkOutput("A_update", bus0.Update, 32'd1);
    checkOutput("A_busy",   bus0.busy, 32'd1);
    checkOutput("A_type",   bus0.cur_type, 32'd1);
    checkOutput("A_blkx",   bus0.blk_x, 32'h6543);
    checkOutput("A_blky",   bus0.blk_y, 32'h10842);
    checkOutput("A_rd0",    {bus0.occ_rd, bus0.occ_x, bus0.occ_y}, {22'd0, 1'b1, 4'd3, 5'd2});
    watch0(9, updCnt, doneIdx, doneCnt, busyLow, goIdx);
    checkOutput("A_updcnt",  updCnt, 32'd0);
    checkOutput("A_doneidx", doneIdx, 32'd8);
    checkOutput("A_donecnt", doneCnt, 32'd1);
    checkOutput("A_goidx",   goIdx, -32'sd1);
    checkOutput("A_nreads",  reads0.size(), 32'd4);
    checkOutput("A_read0",   reads0.size() > 0 ? reads0[0] : 9'h1ff, {4'd3, 5'd2});
    checkOutput("A_read1",   reads0.size() > 1 ? reads0[1] : 9'h1ff, {4'd4, 5'd2});
    checkOutput("A_read2",   reads0.size() > 2 ? reads0[2] : 9'h1ff, {4'd5, 5'd2});
    checkOutput("A_read3",   reads0.size() > 3 ? reads0[3] : 9'h1ff, {4'd6, 5'd2});

    // Type 0 maps to the square; next_type changes after acceptance are ignored.
    applyStimulus(3'd0, 1'b0);
    bus0.next_type = 3'd7;
    checkOutput("B_type", bus0.cur_type, 32'd4);
    checkOutput("B_blkx", bus0.blk_x, 32'h5544);
    checkOutput("B_blky", bus0.blk_y, 32'h10441);
    watch0(9, updCnt, doneIdx, doneCnt, busyLow, goIdx);
    checkOutput("B_doneidx", doneIdx, 32'd8);
    checkOutput("B_type_hold", bus0.cur_type, 32'd4);
    checkOutput("B_goidx", goIdx, -32'sd1);

    // Request held high: one acceptance every 9 cycles.
    applyStimulus(3'd1, 1'b1);
    checkOutput("H_update0", bus0.Update, 32'd1);
    watch0(26, updCnt, doneIdx, doneCnt, busyLow, goIdx);
    bus0.spawn_req = 1'b0;
    checkOutput("H_updcnt",  updCnt, 32'd2);
    checkOutput("H_busylow", busyLow, 32'd3);
    checkOutput("H_donecnt", doneCnt, 32'd3);

    // Reset during WT1 aborts the spawn; a fresh type 4 request then completes.
    applyStimulus(3'd2, 1'b0);
    watch0(3, updCnt, doneIdx, doneCnt, busyLow, goIdx);
    checkOutput("R_busy_pre", bus0.busy, 32'd1);
    rstN = 1'b0;
    #2;
    checkReset("R_mid");
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(3'd4, 1'b0);
    checkOutput("R_update", bus0.Update, 32'd1);
    checkOutput("R_type",   bus0.cur_type, 32'd4);
    checkOutput("R_blkx",   bus0.blk_x, 32'h5544);
    watch0(9, updCnt, doneIdx, doneCnt, busyLow, goIdx);
    checkOutput("R_doneidx", doneIdx, 32'd8);
    checkOutput("R_nreads",  reads0.size(), 32'd4);
    checkOutput("R_goidx",   goIdx, -32'sd1);

    // Cell (4,1) filled, type 7 collides on its second block.
    board[4][1] = 1'b1;
    applyStimulus(3'd7, 1'b0);
    checkOutput("C_blkx", bus0.blk_x, 32'h5443);
    checkOutput("C_blky", bus0.blk_y, 32'h10821);
    watch0(9, updCnt, doneIdx, doneCnt, busyLow, goIdx);
    checkOutput("C_doneidx", doneIdx, 32'd8);
    checkOutput("C_goidx",   goIdx, 32'd8);
    checkOutput("C_busy",    bus0.busy, 32'd0);
    checkOutput("C_read1",   reads0.size() > 1 ? reads0[1] : 9'h1ff, {4'd4, 5'd1});

    // Game over: later requests are dropped and outputs hold.
    applyStimulus(3'd1, 1'b0);
    checkOutput("O_update0", bus0.Update, 32'd0);
    watch0(9, updCnt, doneIdx, doneCnt, busyLow, goIdx);
    checkOutput("O_updcnt",  updCnt, 32'd0);
    checkOutput("O_busylow", busyLow, 32'd9);
    checkOutput("O_nreads",  reads0.size(), 32'd0);
    checkOutput("O_type",    bus0.cur_type, 32'd7);
    checkOutput("O_blkx",    bus0.blk_x, 32'h5443);
    checkOutput("O_gameover", bus0.game_over, 32'd1);

    // Shifted spawn frame: columns 10 and 11 lie off the board.
    reads1.delete();
    @(negedge clk);
    bus1.next_type = 3'd1;
    bus1.spawn_req = 1'b1;
    @(negedge clk);
    bus1.spawn_req = 1'b0;
    checkOutput("X_blkx", bus1.blk_x, 32'hBA98);
    d1Idx = -1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus1.spawn_done === 1'b1 && d1Idx < 0) d1Idx = c;
    end
    checkOutput("X_doneidx",  d1Idx, 32'd8);
    checkOutput("X_gameover", bus1.game_over, 32'd1);
    checkOutput("X_nreads",   reads1.size(), 32'd2);
    checkOutput("X_read0",    reads1.size() > 0 ? reads1[0] : 9'h1ff, {4'd8, 5'd2});
    checkOutput("X_read1",    reads1.size() > 1 ? reads1[1] : 9'h1ff, {4'd9, 5'd2});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
